crop_sequencer: RTL

- Top-level controller for the cropping datapath.
- On start it runs the bounding-box engine over the source pixel RAM, then takes the source RAM read port and copies the boxed region row-major into the destination RAM.
- Owns the source-RAM mux select so the bbox engine and the copy path never drive the RAM in the same cycle.
- Exposes busy/done/err status to the top level; a bench polls done.

---
 rtl/crop_pkg.sv | 15 +
 rtl/crop_addr_gen.sv | 69 ++++++
 rtl/crop_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/crop_pkg.sv
// Shared types and constants for the crop sequencer and its address generator.
package crop_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    CHECK = 3'd2,
    COPY  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int CROP_MARGIN = 2;

endpackage

// File: rtl/crop_addr_gen.sv
// Walks the crop box row-major: source address (row_base + x), last-pixel flag
// and the destination write pointer. Loaded once per crop, stepped once per read.
module crop_addr_gen
  import crop_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int ADDR_W = 16,
  parameter int XW     = 8,
  parameter int YW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              wr_i,
  input  logic [XW-1:0]     left_i,
  input  logic [XW-1:0]     right_i,
  input  logic [YW-1:0]     top_i,
  input  logic [YW-1:0]     bottom_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] dst_ptr_o
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic [XW-1:0]     x_q, left_q, right_q;
  logic [YW-1:0]     y_q, bottom_q;
  logic [ADDR_W-1:0] row_base_q, dst_ptr_q;

  // The only multiply happens at load time; stepping uses additions alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      left_q     <= '0;
      right_q    <= '0;
      bottom_q   <= '0;
      row_base_q <= '0;
      dst_ptr_q  <= '0;
    end else if (load_i) begin
      x_q        <= left_i;
      y_q        <= top_i;
      left_q     <= left_i;
      right_q    <= right_i;
      bottom_q   <= bottom_i;
      row_base_q <= ADDR_W'(top_i) * ROW_STEP;
      dst_ptr_q  <= '0;
    end else begin
      if (step_i) begin
        if (x_q == right_q) begin
          x_q        <= left_q;
          y_q        <= y_q + YW'(1);
          row_base_q <= row_base_q + ROW_STEP;
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
      if (wr_i) begin
        dst_ptr_q <= dst_ptr_q + ADDR_W'(1);
      end
    end
  end

  assign addr_o    = row_base_q + ADDR_W'(x_q);
  assign last_o    = (x_q == right_q) && (y_q == bottom_q);
  assign dst_ptr_o = dst_ptr_q;

endmodule

// File: rtl/crop_sequencer.sv
// Crop controller: runs the bbox engine, validates the box, then copies it row-major
// into the destination RAM. Define CROP_MARGIN_EN to grow the box by CROP_MARGIN per side.
module crop_sequencer
  import crop_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int PIX_W  = 24,
  parameter int ADDR_W = 16,
  parameter int XW     = 8,
  parameter int YW     = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bbox_start,
  input  logic              bbox_done,
  input  logic              bbox_empty,
  input  logic [XW-1:0]     bbox_left,
  input  logic [XW-1:0]     bbox_right,
  input  logic [YW-1:0]     bbox_top,
  input  logic [YW-1:0]     bbox_bottom,
  output logic              ram_sel,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  input  logic [PIX_W-1:0]  src_rdata,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              dst_we,
  output logic [PIX_W-1:0]  dst_wdata,
  output logic [XW:0]       crop_w,
  output logic [YW:0]       crop_h
);

  localparam logic [XW:0] IMG_W_X = (XW+1)'(IMG_W);
  localparam logic [YW:0] IMG_H_Y = (YW+1)'(IMG_H);

  state_e state_q, state_d;

  logic [XW-1:0]     left_q, right_q;
  logic [YW-1:0]     top_q, bottom_q;
  logic              empty_q, err_q, bbox_start_q, wr_pend_q;
  logic [XW:0]       crop_w_q;
  logic [YW:0]       crop_h_q;
  logic              start_acc, ag_load, ag_last, box_bad;
  logic [ADDR_W-1:0] ag_addr, ag_dst_ptr;
  logic [XW-1:0]     exp_l;
  logic [XW:0]       exp_r;
  logic [YW-1:0]     exp_t;
  logic [YW:0]       exp_b;

  assign box_bad = empty_q || (left_q > right_q) || (top_q > bottom_q) ||
                   ({1'b0, right_q} >= IMG_W_X) || ({1'b0, bottom_q} >= IMG_H_Y);

`ifdef CROP_MARGIN_EN
  localparam logic [XW-1:0] MARGIN_X  = XW'(CROP_MARGIN);
  localparam logic [XW:0]   MARGIN_XE = (XW+1)'(CROP_MARGIN);
  localparam logic [YW-1:0] MARGIN_Y  = YW'(CROP_MARGIN);
  localparam logic [YW:0]   MARGIN_YE = (YW+1)'(CROP_MARGIN);
  localparam logic [XW:0]   X_MAX     = IMG_W_X - (XW+1)'(1);
  localparam logic [YW:0]   Y_MAX     = IMG_H_Y - (YW+1)'(1);

  // Expansion is computed from the raw box; only a box that passed validation is loaded.
  assign exp_l = (left_q >= MARGIN_X) ? left_q - MARGIN_X : '0;
  assign exp_t = (top_q >= MARGIN_Y) ? top_q - MARGIN_Y : '0;
  assign exp_r = ({1'b0, right_q} + MARGIN_XE > X_MAX) ? X_MAX : {1'b0, right_q} + MARGIN_XE;
  assign exp_b = ({1'b0, bottom_q} + MARGIN_YE > Y_MAX) ? Y_MAX : {1'b0, bottom_q} + MARGIN_YE;
`else
  assign exp_l = left_q;
  assign exp_t = top_q;
  assign exp_r = {1'b0, right_q};
  assign exp_b = {1'b0, bottom_q};
`endif

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    ram_sel   = 1'b0;
    src_rd    = 1'b0;
    ag_load   = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          start_acc = 1'b1;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (bbox_done) state_d = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        ag_load = !box_bad;
        state_d = box_bad ? DONE : COPY;
      end
      COPY: begin
        busy    = 1'b1;
        ram_sel = 1'b1;
        src_rd  = 1'b1;
        if (ag_last) state_d = DRAIN;
      end
      // Source port stays ours until the last returned pixel has been written.
      DRAIN: begin
        busy    = 1'b1;
        ram_sel = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d   = SCAN;
          start_acc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      left_q       <= '0;
      right_q      <= '0;
      top_q        <= '0;
      bottom_q     <= '0;
      empty_q      <= 1'b0;
      err_q        <= 1'b0;
      bbox_start_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      crop_w_q     <= '0;
      crop_h_q     <= '0;
    end else begin
      state_q      <= state_d;
      bbox_start_q <= start_acc;
      wr_pend_q    <= src_rd;
      if (start_acc) err_q <= 1'b0;
      if (state_q == SCAN && bbox_done) begin
        left_q   <= bbox_left;
        right_q  <= bbox_right;
        top_q    <= bbox_top;
        bottom_q <= bbox_bottom;
        empty_q  <= bbox_empty;
      end
      if (state_q == CHECK) begin
        err_q <= box_bad;
        if (!box_bad) begin
          crop_w_q <= exp_r - {1'b0, exp_l} + (XW+1)'(1);
          crop_h_q <= exp_b - {1'b0, exp_t} + (YW+1)'(1);
        end
      end
    end
  end

  crop_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W),
    .XW     (XW),
    .YW     (YW)
  ) u_addr_gen (
    .clk       (CLOCK_50),
    .rst       (reset),
    .load_i    (ag_load),
    .step_i    (src_rd),
    .wr_i      (wr_pend_q),
    .left_i    (exp_l),
    .right_i   (exp_r[XW-1:0]),
    .top_i     (exp_t),
    .bottom_i  (exp_b[YW-1:0]),
    .addr_o    (ag_addr),
    .last_o    (ag_last),
    .dst_ptr_o (ag_dst_ptr)
  );

  assign bbox_start = bbox_start_q;
  assign err        = err_q;
  assign crop_w     = crop_w_q;
  assign crop_h     = crop_h_q;
  assign src_addr   = src_rd ? ag_addr : '0;
  assign dst_we     = wr_pend_q;
  assign dst_addr   = wr_pend_q ? ag_dst_ptr : '0;
  assign dst_wdata  = wr_pend_q ? src_rdata : '0;

endmodule
